sweep_arbiter: RTL and testbench
================================

SWEEP_ARBITER -- requirements
Module: sweep_arbiter

Interface
REQ-001 SHALL have parameter FILES, default 8, squares per rank; power of two, 2..16.
REQ-002 SHALL have parameter RANKS, default 8, ranks per board; power of two, 2..16.
REQ-003 SHALL have parameter PRIO_W, default 3, priority width; SQ_W = log2(FILES*RANKS) is derived, never set.
REQ-004 SHALL use one clock; reset is asynchronous and active-high: clk  input  1  rising-edge clock.
REQ-005 SHALL have rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have cmd_valid  input  1  command offered.
REQ-007 SHALL have cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-008 SHALL have cmd_op  input  2  0 SWEEP, 1 ENABLE_ALL, 2 SET_ENABLE, 3 NOP.
REQ-009 SHALL have cmd_sq  input  SQ_W  target square for SET_ENABLE, rotation-corrected.
REQ-010 SHALL have cmd_val  input  1  enable value for SET_ENABLE.
REQ-011 SHALL have rotated  input  1  board currently rotated 180 degrees.
REQ-012 SHALL have rank_sel  output  log2(RANKS)  rank presented to the stage.
REQ-013 SHALL have enable_row  output  FILES  enable bits of rank_sel.
REQ-014 SHALL have prio_row  input  FILES*PRIO_W  per-file priority, combinational from rank_sel.
REQ-015 SHALL have illegal_row  input  FILES  per-file illegal flags, combinational from rank_sel.
REQ-016 SHALL have res_valid  output  1  result available.
REQ-017 SHALL have res_ready  input  1  result consumed.
REQ-018 SHALL have res_sq, res_prio, res_none, res_illegal  outputs  SQ_W, PRIO_W, 1, 1  winning square, its priority, no candidate, any illegal seen.

Function
REQ-019 SHALL implement states IDLE, SCAN, HOLD; cmd_ready = (state == IDLE).
REQ-020 SHALL, on SWEEP handshake, clear best, set rank_sel=0, enter SCAN next edge.
REQ-021 SHALL, in SCAN, sample prio_row/illegal_row each cycle and increment rank_sel; after rank RANKS-1 enter HOLD; latency from accept edge to res_valid = RANKS+1 cycles.
REQ-022 SHALL replace best only on strictly greater priority; ties keep lowest index (rank ascending, then file ascending).
REQ-023 SHALL index square = rank*FILES + file; res_sq = square XOR all-ones when rotated=1, unchanged otherwise; rotated is sampled at accept.
REQ-024 SHALL assert res_none and drive res_sq=0, res_prio=0 when best priority is 0.
REQ-025 SHALL OR all illegal_row bits over the sweep into res_illegal.
REQ-026 SHALL hold res_* stable in HOLD until res_valid & res_ready, then return to IDLE.
REQ-027 SHALL execute ENABLE_ALL and SET_ENABLE in one edge in IDLE, staying IDLE; SET_ENABLE writes bit (cmd_sq XOR all-ones if rotated).
REQ-028 SHALL drive rank_sel=0 and enable_row of rank 0 outside SCAN.

Reset
REQ-029 SHALL, on rst at any time including mid-SCAN, enter IDLE, set all enables to 1, clear res_valid, res_sq, res_prio, res_illegal, rank_sel; res_none = 1.

Configuration
REQ-030 SHALL, with SWEEP_AUTO_MASK_EN defined, clear the enable bit of the winning (un-rotated) square on the result handshake when res_none=0.
REQ-031 SHALL, without SWEEP_AUTO_MASK_EN, leave enables unchanged by result handshakes.

Structure
REQ-032 SHALL place op encodings, state enum and priority constants in shared package chess_pkg.
REQ-033 SHALL contain one sub-module, sweep_cmp, comparing one (prio, square) pair against the running best.

Verification
REQ-034 SHALL test: all prio 0, SWEEP -> res_valid at cycle 9, res_none=1, res_sq=0.
REQ-035 SHALL test: prio 6 at squares 12 and 40 -> res_sq=12, res_prio=6.
REQ-036 SHALL test: rotated=1, prio 4 at square 3 -> res_sq=60.
REQ-037 SHALL test: illegal at rank 5 file 2 only -> res_illegal=1; next sweep without it -> 0.
REQ-038 SHALL test: rst asserted at SCAN rank 4 -> next cycle IDLE, res_valid=0, cmd_ready=1.
REQ-039 SHALL test: with SWEEP_AUTO_MASK_EN, prio 5 at square 20 and prio 3 at 7, two sweeps -> 20 then 7.

Source files
------------

// File: rtl/chess_pkg.sv
// Shared types for the sweep arbiter: command opcodes, FSM states and priority constants.
package chess_pkg;

  typedef enum logic [1:0] {
    OP_SWEEP      = 2'd0,
    OP_ENABLE_ALL = 2'd1,
    OP_SET_ENABLE = 2'd2,
    OP_NOP        = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // A best priority of PRIO_NONE means no candidate was found.
  localparam int PRIO_NONE = 0;

endpackage

// File: rtl/sweep_cmp.sv
// One link of the per-rank compare chain: a candidate displaces the running best
// only with strictly greater priority, so earlier (lower-index) squares win ties.
module sweep_cmp #(
  parameter int PRIO_W = 3,
  parameter int SQ_W   = 6
) (
  input  logic [PRIO_W-1:0] best_prio,
  input  logic [SQ_W-1:0]   best_sq,
  input  logic [PRIO_W-1:0] cand_prio,
  input  logic [SQ_W-1:0]   cand_sq,
  output logic [PRIO_W-1:0] win_prio,
  output logic [SQ_W-1:0]   win_sq
);

  logic take;

  assign take     = cand_prio > best_prio;
  assign win_prio = take ? cand_prio : best_prio;
  assign win_sq   = take ? cand_sq   : best_sq;

endmodule

// File: rtl/sweep_arbiter.sv
// Rank-by-rank priority sweep over a FILES x RANKS board with per-square enables.
// Optional feature: define SWEEP_AUTO_MASK_EN to clear the winner's enable on result handshake.
module sweep_arbiter
  import chess_pkg::*;
#(
  parameter  int FILES  = 8,
  parameter  int RANKS  = 8,
  parameter  int PRIO_W = 3,
  localparam int SQ_W   = $clog2(FILES * RANKS),
  localparam int RANK_W = $clog2(RANKS)
) (
  input  logic                    clk,
  input  logic                    rst,
  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid is held with stable payload until that edge.
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic [SQ_W-1:0]         cmd_sq,
  input  logic                    cmd_val,
  input  logic                    rotated,
  output logic [RANK_W-1:0]       rank_sel,
  output logic [FILES-1:0]        enable_row,
  input  logic [FILES*PRIO_W-1:0] prio_row,
  input  logic [FILES-1:0]        illegal_row,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [SQ_W-1:0]         res_sq,
  output logic [PRIO_W-1:0]       res_prio,
  output logic                    res_none,
  output logic                    res_illegal,
  output state_e                  dbg_state
);

  localparam int FILE_W = $clog2(FILES);
  localparam int NSQ    = FILES * RANKS;

  state_e             state;
  logic [RANK_W-1:0]  rank_q;
  logic [NSQ-1:0]     en_q;
  logic [PRIO_W-1:0]  best_prio;
  logic [SQ_W-1:0]    best_sq;
  logic               ill_acc;
  logic               rot_q;
  logic [SQ_W-1:0]    row_base;
  logic [SQ_W-1:0]    set_idx;

  logic [PRIO_W-1:0]  chain_prio [FILES+1];
  logic [SQ_W-1:0]    chain_sq   [FILES+1];

  assign cmd_ready  = (state == ST_IDLE);
  assign dbg_state  = state;
  // rank_q wraps to 0 after the last rank, so it already reads 0 outside SCAN.
  assign rank_sel   = rank_q;
  assign row_base   = {rank_q, {FILE_W{1'b0}}};
  assign enable_row = en_q[row_base +: FILES];
  assign set_idx    = rotated ? ~cmd_sq : cmd_sq;

  assign chain_prio[0] = best_prio;
  assign chain_sq[0]   = best_sq;

  for (genvar f = 0; f < FILES; f++) begin : g_cmp
    sweep_cmp #(
      .PRIO_W (PRIO_W),
      .SQ_W   (SQ_W)
    ) u_cmp (
      .best_prio (chain_prio[f]),
      .best_sq   (chain_sq[f]),
      .cand_prio (prio_row[f*PRIO_W +: PRIO_W]),
      .cand_sq   ({rank_q, FILE_W'(f)}),
      .win_prio  (chain_prio[f+1]),
      .win_sq    (chain_sq[f+1])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      rank_q      <= '0;
      en_q        <= '1;
      best_prio   <= '0;
      best_sq     <= '0;
      ill_acc     <= 1'b0;
      rot_q       <= 1'b0;
      res_valid   <= 1'b0;
      res_sq      <= '0;
      res_prio    <= '0;
      res_none    <= 1'b1;
      res_illegal <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            case (op_e'(cmd_op))
              OP_SWEEP: begin
                best_prio <= '0;
                best_sq   <= '0;
                ill_acc   <= 1'b0;
                rot_q     <= rotated;
                rank_q    <= '0;
                state     <= ST_SCAN;
              end
              OP_ENABLE_ALL: en_q <= '1;
              OP_SET_ENABLE: en_q[set_idx] <= cmd_val;
              default: ;
            endcase
          end
        end
        ST_SCAN: begin
          best_prio <= chain_prio[FILES];
          best_sq   <= chain_sq[FILES];
          ill_acc   <= ill_acc | (|illegal_row);
          rank_q    <= rank_q + 1'b1;
          if (rank_q == RANK_W'(RANKS - 1)) state <= ST_HOLD;
        end
        ST_HOLD: begin
          // First HOLD cycle publishes the result; later cycles wait for the consumer.
          if (!res_valid) begin
            res_valid   <= 1'b1;
            res_illegal <= ill_acc;
            if (best_prio == PRIO_W'(PRIO_NONE)) begin
              res_none <= 1'b1;
              res_sq   <= '0;
              res_prio <= '0;
            end else begin
              res_none <= 1'b0;
              res_sq   <= rot_q ? ~best_sq : best_sq;
              res_prio <= best_prio;
            end
          end else if (res_ready) begin
            res_valid <= 1'b0;
            state     <= ST_IDLE;
`ifdef SWEEP_AUTO_MASK_EN
            if (!res_none) en_q[best_sq] <= 1'b0;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sweep_arbiter.sv
// Directed bench for sweep_arbiter on an 8x8 board; a stage model turns a priority table into rows.
module tb_sweep_arbiter;
  import chess_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd3;
  logic [5:0]  cmd_sq = '0;
  logic        cmd_val = 1'b0;
  logic        rotated = 1'b0;
  logic [2:0]  rank_sel;
  logic [7:0]  enable_row;
  logic [23:0] prio_row;
  logic [7:0]  illegal_row;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [5:0]  res_sq;
  logic [2:0]  res_prio;
  logic        res_none;
  logic        res_illegal;
  state_e      dbg_state;

  logic [2:0]  prio_tab [64];
  logic        ill_tab  [64];

  int n_checks = 0;
  int n_errors = 0;

  sweep_arbiter #(.FILES(8), .RANKS(8), .PRIO_W(3)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_sq(cmd_sq), .cmd_val(cmd_val), .rotated(rotated),
    .rank_sel(rank_sel), .enable_row(enable_row),
    .prio_row(prio_row), .illegal_row(illegal_row),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sq(res_sq), .res_prio(res_prio), .res_none(res_none),
    .res_illegal(res_illegal), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Stage model: a disabled square presents priority 0.
  always_comb begin
    int sq;
    sq          = 0;
    prio_row    = '0;
    illegal_row = '0;
    for (int f = 0; f < 8; f++) begin
      sq = int'(rank_sel) * 8 + f;
      if (enable_row[f]) prio_row[f*3 +: 3] = prio_tab[sq];
      illegal_row[f] = ill_tab[sq];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_tabs();
    for (int i = 0; i < 64; i++) begin
      prio_tab[i] = '0;
      ill_tab[i]  = 1'b0;
    end
  endtask

  // driver tasks: called and returning at #1 after a rising edge
  task automatic do_cmd(input logic [1:0] op, input logic [5:0] sq, input logic val, input logic rot);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_sq    = sq;
    cmd_val   = val;
    rotated   = rot;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'd3;
    rotated   = 1'b0;
  endtask

  task automatic sweep(input string tag, input logic rot, input logic [5:0] e_sq,
                       input logic [2:0] e_prio, input logic e_none, input logic e_ill);
    int cnt;
    check({tag, "_ready"}, cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = 2'd0;
    rotated   = rot;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'd3;
    rotated   = ~rot;  // rotation must have been captured at accept
    cnt = 0;
    while (!res_valid && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
    end
    check({tag, "_lat"}, cnt, 9);
    check({tag, "_sq"}, res_sq, e_sq);
    check({tag, "_prio"}, res_prio, e_prio);
    check({tag, "_none"}, res_none, e_none);
    check({tag, "_ill"}, res_illegal, e_ill);
    repeat (2) begin @(posedge clk); #1; end
    check({tag, "_hold_v"}, res_valid, 1);
    check({tag, "_hold_sq"}, res_sq, e_sq);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    rotated   = 1'b0;
    check({tag, "_done_v"}, res_valid, 0);
    check({tag, "_done_rdy"}, cmd_ready, 1);
  endtask

  initial begin
    int cnt;
    clear_tabs();
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", cmd_ready, 1);
    check("rst_valid", res_valid, 0);
    check("rst_none", res_none, 1);
    check("rst_sq", res_sq, 0);
    check("rst_rank", rank_sel, 0);
    check("rst_en", enable_row, 8'hFF);
    rst = 1'b0;
    @(posedge clk); #1;

    sweep("zero", 1'b0, 6'd0, 3'd0, 1'b1, 1'b0);

    prio_tab[12] = 3'd6; prio_tab[40] = 3'd6;
    sweep("tie", 1'b0, 6'd12, 3'd6, 1'b0, 1'b0);

    clear_tabs();
    prio_tab[17] = 3'd7; prio_tab[18] = 3'd7;
    sweep("tie_row", 1'b0, 6'd17, 3'd7, 1'b0, 1'b0);

    clear_tabs();
    prio_tab[0] = 3'd2; prio_tab[63] = 3'd5;
    sweep("last", 1'b0, 6'd63, 3'd5, 1'b0, 1'b0);

    clear_tabs();
    prio_tab[3] = 3'd4;
    sweep("rot", 1'b1, 6'd60, 3'd4, 1'b0, 1'b0);

    clear_tabs();
    ill_tab[42] = 1'b1;
    sweep("ill_on", 1'b0, 6'd0, 3'd0, 1'b1, 1'b1);
    ill_tab[42] = 1'b0;
    sweep("ill_off", 1'b0, 6'd0, 3'd0, 1'b1, 1'b0);

    do_cmd(2'd2, 6'd2, 1'b0, 1'b0);
    check("set_en_clr", enable_row, 8'hFB);
    check("set_en_idle", cmd_ready, 1);
    do_cmd(2'd2, 6'd61, 1'b1, 1'b1);
    check("set_en_rot", enable_row, 8'hFF);
    prio_tab[12] = 3'd6; prio_tab[40] = 3'd6;
    do_cmd(2'd2, 6'd12, 1'b0, 1'b0);
    sweep("masked", 1'b0, 6'd40, 3'd6, 1'b0, 1'b0);
    do_cmd(2'd1, 6'd0, 1'b0, 1'b0);
    sweep("en_all", 1'b0, 6'd12, 3'd6, 1'b0, 1'b0);

    clear_tabs();
    prio_tab[20] = 3'd5; prio_tab[7] = 3'd3;
    sweep("amask1", 1'b0, 6'd20, 3'd5, 1'b0, 1'b0);
`ifdef SWEEP_AUTO_MASK_EN
    sweep("amask2", 1'b0, 6'd7, 3'd3, 1'b0, 1'b0);
`else
    sweep("amask2", 1'b0, 6'd20, 3'd5, 1'b0, 1'b0);
`endif
    do_cmd(2'd1, 6'd0, 1'b0, 1'b0);

    // reset in the middle of a sweep
    do_cmd(2'd2, 6'd2, 1'b0, 1'b0);
    do_cmd(2'd0, 6'd0, 1'b0, 1'b0);
    cnt = 0;
    while (rank_sel != 3'd4 && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("mid_rank", rank_sel, 4);
    check("mid_state", 32'(dbg_state), 32'(ST_SCAN));
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("mid_rst_valid", res_valid, 0);
    check("mid_rst_ready", cmd_ready, 1);
    check("mid_rst_rank", rank_sel, 0);
    check("mid_rst_none", res_none, 1);
    check("mid_rst_en", enable_row, 8'hFF);
    rst = 1'b0;
    @(posedge clk); #1;
    sweep("after_rst", 1'b0, 6'd20, 3'd5, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
